vend_txn_ctrl: RTL and testbench

Transaction sequencer for the vending machine. Accumulates coin credit, accepts or refuses a product selection against its price, and handshakes with the dispenser. It then pays change one unit at a time and issues a clean accumulator-clear pulse at the end of every transaction. It replaces ad-hoc combinational reset gating of the credit path with an explicit sequenced controller; all money values are in units of 5 cents.

---
 rtl/vend_pkg.sv | 28 ++
 rtl/vend_timeout_cnt.sv | 30 +++
 rtl/vend_txn_ctrl.sv | 170 +++++++++++++++++
 tb/tb_vend_txn_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and coin constants for the vending transaction controller.
package vend_pkg;

  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

  localparam logic [1:0] COIN_5C  = 2'b00;
  localparam logic [1:0] COIN_10C = 2'b01;
  localparam logic [1:0] COIN_25C = 2'b10;
  localparam logic [1:0] COIN_INV = 2'b11;

  localparam int unsigned UNITS_W   = 3;
  localparam logic [2:0]  UNITS_5C  = 3'd1;
  localparam logic [2:0]  UNITS_10C = 3'd2;
  localparam logic [2:0]  UNITS_25C = 3'd5;

  localparam int unsigned UNIT_CENTS = 5;

  // Credit units carried by a coin code; the invalid code is worth nothing.
  function automatic logic [UNITS_W-1:0] coin_units(input logic [1:0] code);
    case (code)
      COIN_5C:  coin_units = UNITS_5C;
      COIN_10C: coin_units = UNITS_10C;
      COIN_25C: coin_units = UNITS_25C;
      default:  coin_units = '0;
    endcase
  endfunction

endpackage

// File: rtl/vend_timeout_cnt.sv
// Loadable saturating down-counter with clear; expired_c flags a count of zero.
module vend_timeout_cnt #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired_c = (count == '0);

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: credit accumulation, selection, dispense
// handshake, unit-by-unit change and end-of-transaction accumulator clear.
module vend_txn_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W    = 6,
  parameter int unsigned CREDIT_MAX  = 40,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned CHG_GAP     = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                coin_valid,
  input  logic [1:0]          coin_value,
  input  logic                sel_valid,
  input  logic [CREDIT_W-1:0] sel_price,
  input  logic                cancel,
  input  logic                dispense_ack,
  output logic                dispense_req,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                sel_nack,
  output logic                acc_clear,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned GAP_W = (CHG_GAP > 1) ? $clog2(CHG_GAP + 1) : 1;

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic                dispense_req_nxt, change_pulse_nxt, coin_reject_nxt;
  logic                sel_nack_nxt, acc_clear_nxt;
  logic                tmo_load, tmo_dec, tmo_clr, tmo_expired;
  logic                gap_load, gap_dec, gap_clr, gap_expired;
  logic                coin_ok, any_strobe;
  logic [CREDIT_W:0]   coin_sum;

  vend_timeout_cnt #(.W(TMO_W)) u_tmo (
    .clk(clk), .resetn(resetn), .clr(tmo_clr), .load(tmo_load),
    .load_val(TMO_W'(TIMEOUT_CYC - 1)), .dec(tmo_dec), .expired_c(tmo_expired)
  );

  vend_timeout_cnt #(.W(GAP_W)) u_gap (
    .clk(clk), .resetn(resetn), .clr(gap_clr), .load(gap_load),
    .load_val(GAP_W'(CHG_GAP)), .dec(gap_dec), .expired_c(gap_expired)
  );

  always_comb begin
    state_nxt        = state;
    credit_nxt       = credit;
    dispense_req_nxt = dispense_req;
    change_pulse_nxt = 1'b0;
    coin_reject_nxt  = 1'b0;
    sel_nack_nxt     = 1'b0;
    acc_clear_nxt    = 1'b0;
    tmo_load         = 1'b0;
    tmo_dec          = 1'b0;
    gap_load         = 1'b0;
    gap_dec          = 1'b0;
    coin_ok          = coin_valid && (coin_value != COIN_INV);
    any_strobe       = coin_valid || sel_valid || cancel;
    coin_sum         = {1'b0, credit} + (CREDIT_W+1)'(coin_units(coin_value));

    unique case (state)
      IDLE: begin
        if (coin_ok) begin
          credit_nxt = CREDIT_W'(coin_units(coin_value));
          state_nxt  = CREDIT;
          tmo_load   = 1'b1;
        end else if (coin_valid) begin
          coin_reject_nxt = 1'b1;
        end
        sel_nack_nxt = sel_valid;
      end

      CREDIT: begin
        // Any strobe restarts the idle window; expiry refunds via CHANGE.
        if (any_strobe) tmo_load = 1'b1;
        else if (tmo_expired) state_nxt = CHANGE;
        else tmo_dec = 1'b1;

        if (cancel) begin
          state_nxt       = CHANGE;
          coin_reject_nxt = coin_valid;
        end else if (sel_valid) begin
          coin_reject_nxt = coin_valid;
          if ((sel_price == '0) || (sel_price > credit)) begin
            sel_nack_nxt = 1'b1;
          end else begin
            credit_nxt       = credit - sel_price;
            dispense_req_nxt = 1'b1;
            state_nxt        = DISPENSE;
          end
        end else if (coin_valid) begin
          if (coin_ok && (coin_sum <= (CREDIT_W+1)'(CREDIT_MAX)))
            credit_nxt = coin_sum[CREDIT_W-1:0];
          else
            coin_reject_nxt = 1'b1;
        end
      end

      DISPENSE: begin
        coin_reject_nxt = coin_valid;
        sel_nack_nxt    = sel_valid;
        if (dispense_ack) begin
          dispense_req_nxt = 1'b0;
          if (credit != '0) begin
            state_nxt = CHANGE;
          end else begin
            state_nxt     = IDLE;
            acc_clear_nxt = 1'b1;
          end
        end
      end

      CHANGE: begin
        coin_reject_nxt = coin_valid;
        sel_nack_nxt    = sel_valid;
        // One-cycle pulse, then CHG_GAP low cycles before the next unit.
        if (change_pulse) begin
          if (credit == '0) begin
            state_nxt     = IDLE;
            acc_clear_nxt = 1'b1;
          end else begin
            gap_dec = 1'b1;
          end
        end else if (!gap_expired) begin
          gap_dec = 1'b1;
        end else if (credit == '0) begin
          state_nxt     = IDLE;
          acc_clear_nxt = 1'b1;
        end else begin
          change_pulse_nxt = 1'b1;
          credit_nxt       = credit - CREDIT_W'(1);
          gap_load         = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    tmo_clr = (state_nxt != CREDIT);
    gap_clr = (state != CHANGE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      credit       <= '0;
      dispense_req <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      sel_nack     <= 1'b0;
      acc_clear    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      credit       <= credit_nxt;
      dispense_req <= dispense_req_nxt;
      change_pulse <= change_pulse_nxt;
      coin_reject  <= coin_reject_nxt;
      sel_nack     <= sel_nack_nxt;
      acc_clear    <= acc_clear_nxt;
      busy         <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Scoreboard bench for vend_txn_ctrl: expected output events are queued as
// stimulus is driven and matched against the pulses the controller produces.
module tb_vend_txn_ctrl;
  import vend_pkg::*;

  localparam int CW = 6;
  localparam int EV_REJ = 1, EV_NACK = 2, EV_DREQ = 3, EV_CHG = 4, EV_CLR = 5;

  logic          clk = 1'b0;
  logic          resetn;
  logic          coin_valid, sel_valid, cancel, dispense_ack;
  logic [1:0]    coin_value;
  logic [CW-1:0] sel_price;
  logic          dispense_req, change_pulse, coin_reject, sel_nack, acc_clear, busy;
  logic [CW-1:0] credit;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  logic prev_dreq = 1'b0;

  vend_txn_ctrl dut (
    .clk(clk), .resetn(resetn), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_price(sel_price), .cancel(cancel),
    .dispense_ack(dispense_ack), .dispense_req(dispense_req),
    .change_pulse(change_pulse), .coin_reject(coin_reject), .sel_nack(sel_nack),
    .acc_clear(acc_clear), .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  function automatic int ev(input int kind, input int cr);
    return kind * 256 + cr;
  endfunction

  function automatic int mk(input int b, input int a, input int p, input int d, input int cr);
    return b * 4096 + a * 2048 + p * 1024 + d * 512 + cr;
  endfunction

  function automatic int outs();
    return mk(int'(busy), int'(acc_clear), int'(change_pulse), int'(dispense_req), int'(credit));
  endfunction

  task automatic sb_pop(input int kind);
    int e;
    if (exp_q.size() == 0) begin
      check_eq("sb_unexpected", ev(kind, int'(credit)), 0);
    end else begin
      e = exp_q.pop_front();
      check_eq("sb_event", ev(kind, int'(credit)), e);
    end
  endtask

  // Output monitor: every pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (resetn) begin
      if (coin_reject) sb_pop(EV_REJ);
      if (sel_nack) sb_pop(EV_NACK);
      if (dispense_req && !prev_dreq) sb_pop(EV_DREQ);
      if (change_pulse) sb_pop(EV_CHG);
      if (acc_clear) sb_pop(EV_CLR);
    end
    prev_dreq = dispense_req;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic cv, input logic [1:0] cval, input logic sv,
                       input logic [CW-1:0] price, input logic cn, input logic ack);
    coin_valid = cv; coin_value = cval; sel_valid = sv;
    sel_price = price; cancel = cn; dispense_ack = ack;
    @(negedge clk);
    coin_valid = 1'b0; coin_value = 2'b00; sel_valid = 1'b0;
    sel_price = '0; cancel = 1'b0; dispense_ack = 1'b0;
  endtask

  task automatic coin(input logic [1:0] code);
    drive(1'b1, code, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic sel(input int price);
    drive(1'b0, COIN_5C, 1'b1, CW'(price), 1'b0, 1'b0);
  endtask

  task automatic push_change(input int from_credit);
    for (int c = from_credit - 1; c >= 0; c--) exp_q.push_back(ev(EV_CHG, c));
    exp_q.push_back(ev(EV_CLR, 0));
  endtask

  int trace1[6];

  initial begin
    resetn = 1'b0;
    coin_valid = 1'b0; coin_value = 2'b00; sel_valid = 1'b0;
    sel_price = '0; cancel = 1'b0; dispense_ack = 1'b0;
    tick(3);
    check_eq("reset_outs", outs(), 0);
    resetn = 1'b1;
    tick(2);
    check_eq("post_reset_outs", outs(), 0);

    // IDLE: invalid coin rejected, selection refused, cancel ignored
    exp_q.push_back(ev(EV_REJ, 0));
    coin(COIN_INV);
    exp_q.push_back(ev(EV_NACK, 0));
    sel(3);
    drive(1'b0, COIN_5C, 1'b0, '0, 1'b1, 1'b0);
    check_eq("idle_cancel", outs(), 0);

    // 25c + 10c, buy at 5, two change units
    coin(COIN_25C);
    check_eq("credit_5", outs(), mk(1, 0, 0, 0, 5));
    coin(COIN_10C);
    check_eq("credit_7", outs(), mk(1, 0, 0, 0, 7));
    exp_q.push_back(ev(EV_DREQ, 2));
    sel(5);
    for (int i = 0; i < 3; i++) begin
      check_eq("dreq_hold", outs(), mk(1, 0, 0, 1, 2));
      tick(1);
    end
    exp_q.push_back(ev(EV_REJ, 2));
    exp_q.push_back(ev(EV_NACK, 2));
    drive(1'b1, COIN_5C, 1'b1, CW'(1), 1'b0, 1'b0);
    check_eq("dreq_busy_strobes", outs(), mk(1, 0, 0, 1, 2));
    push_change(2);
    drive(1'b0, COIN_5C, 1'b0, '0, 1'b0, 1'b1);
    trace1 = '{mk(1, 0, 0, 0, 2), mk(1, 0, 1, 0, 1), mk(1, 0, 0, 0, 1),
               mk(1, 0, 1, 0, 0), mk(0, 1, 0, 0, 0), mk(0, 0, 0, 0, 0)};
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("change_trace%0d", i), outs(), trace1[i]);
      tick(1);
    end

    // Selection above credit refused, then cancel refunds
    coin(COIN_10C);
    exp_q.push_back(ev(EV_NACK, 2));
    sel(4);
    check_eq("nack_credit", outs(), mk(1, 0, 0, 0, 2));
    push_change(2);
    drive(1'b0, COIN_5C, 1'b0, '0, 1'b1, 1'b0);
    tick(8);
    check_eq("cancel_done", outs(), 0);

    // Credit ceiling
    for (int i = 0; i < 7; i++) coin(COIN_25C);
    coin(COIN_10C);
    coin(COIN_5C);
    check_eq("credit_38", outs(), mk(1, 0, 0, 0, 38));
    exp_q.push_back(ev(EV_REJ, 38));
    coin(COIN_25C);
    coin(COIN_10C);
    check_eq("credit_40", outs(), mk(1, 0, 0, 0, 40));
    exp_q.push_back(ev(EV_REJ, 40));
    coin(COIN_INV);
    exp_q.push_back(ev(EV_REJ, 40));
    coin(COIN_5C);
    push_change(40);
    drive(1'b0, COIN_5C, 1'b0, '0, 1'b1, 1'b0);
    tick(90);
    check_eq("max_refund_done", outs(), 0);

    // Cancel beats selection beats coin in the same cycle
    coin(COIN_25C);
    exp_q.push_back(ev(EV_REJ, 5));
    push_change(5);
    drive(1'b1, COIN_5C, 1'b1, CW'(3), 1'b1, 1'b0);
    tick(14);
    check_eq("priority_done", outs(), 0);

    // Idle timeout refund
    coin(COIN_5C);
    tick(999);
    check_eq("tmo_999", outs(), mk(1, 0, 0, 0, 1));
    push_change(1);
    tick(6);
    check_eq("tmo_refund_done", outs(), 0);

    // 999 idle cycles then a coin: no refund
    coin(COIN_5C);
    tick(999);
    coin(COIN_5C);
    check_eq("tmo_restart", outs(), mk(1, 0, 0, 0, 2));
    tick(5);
    check_eq("tmo_no_refund", outs(), mk(1, 0, 0, 0, 2));
    push_change(2);
    drive(1'b0, COIN_5C, 1'b0, '0, 1'b1, 1'b0);
    tick(8);

    // Reset in CHANGE discards credit
    coin(COIN_25C);
    exp_q.push_back(ev(EV_DREQ, 3));
    sel(2);
    drive(1'b0, COIN_5C, 1'b0, '0, 1'b0, 1'b1);
    check_eq("change_entry", outs(), mk(1, 0, 0, 0, 3));
    resetn = 1'b0;
    #1;
    check_eq("async_reset", outs(), 0);
    tick(2);
    resetn = 1'b1;
    tick(5);
    check_eq("reset_no_pulses", outs(), 0);

    // Zero/over price refused, exact price closes with no change
    coin(COIN_25C);
    exp_q.push_back(ev(EV_NACK, 5));
    sel(0);
    exp_q.push_back(ev(EV_NACK, 5));
    sel(6);
    exp_q.push_back(ev(EV_DREQ, 0));
    sel(5);
    exp_q.push_back(ev(EV_CLR, 0));
    drive(1'b0, COIN_5C, 1'b0, '0, 1'b0, 1'b1);
    check_eq("exact_clear", outs(), mk(0, 1, 0, 0, 0));
    tick(5);
    check_eq("exact_idle", outs(), 0);

    check_eq("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
